pipeline_controller: RTL and testbench

- Hazard and sequencing controller for the five-stage IF/ID/EX/MEM/WB RISC-V pipeline.
- Generates per-stage advance enables and flushes from:
  - load-use hazards,
  - taken branches/jumps resolved in EX,
  - a data-memory wait handshake,
  - an ecall halt request.
- Owns a memory-wait timeout watchdog and saturating performance counters.
- Sits beside the stage chain; drives the enable/flush pins of every pipeline register and the PC.

---
 rtl/pipeline_controller.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller for the five-stage IF/ID/EX/MEM/WB pipeline.
// Drives the PC enable, pipeline-register enables/flushes and register-file
// write permit from load-use hazards, EX-resolved taken branches, the data
// memory wait handshake and an ecall halt request. Owns a memory-wait
// watchdog and saturating stall/flush performance counters.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   id_rs1/id_rs2            source register fields of the ID instruction
//   id_uses_rs1/id_uses_rs2  ID instruction actually reads rs1/rs2
//   ex_is_load, ex_rd        EX instruction is a load, and its destination
//   ex_branch_taken          EX resolved a taken branch/jump this cycle
//   mem_req, mem_ready       MEM access in flight / completes this cycle
//   halt_req                 ecall has reached WB
//   pc_en, *_en              PC and pipeline-register load enables
//   if_id_flush/id_ex_flush  clear register to NOP at the edge (beats enable)
//   wb_commit                register-file write permitted
//   halted, mem_error        HALT / ERROR (memory timeout) state flags
//   stall_count, flush_count saturating performance counters
module pipeline_controller #(
   parameter int unsigned MEM_TIMEOUT = 256,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             wb_commit,
   output logic             halted,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // One extra bit so the counter can reach MEM_TIMEOUT without wrapping.
   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_ERROR = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

   logic freeze_c;
   logic lu_hazard_c;

   // Control values before reset gating; counters see these, never rst.
   logic pc_en_c;
   logic if_id_en_c;
   logic id_ex_en_c;
   logic ex_mem_en_c;
   logic mem_wb_en_c;
   logic if_id_flush_c;
   logic id_ex_flush_c;
   logic wb_commit_c;

   // Hazard detection; x0 is never a real dependency.
   assign freeze_c    = mem_req & ~mem_ready;
   assign lu_hazard_c = ex_is_load & (ex_rd != 5'd0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));

   // State, watchdog and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next state, watchdog, counters and stage controls.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      pc_en_c       = 1'b0;
      if_id_en_c    = 1'b0;
      id_ex_en_c    = 1'b0;
      ex_mem_en_c   = 1'b0;
      mem_wb_en_c   = 1'b0;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      wb_commit_c   = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            if (freeze_c) begin
               // Whole pipe holds; a taken branch stays in EX until unfrozen.
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else if (ex_branch_taken) begin
               // Branch wins over load-use: the ID instruction is wrong-path.
               pc_en_c       = 1'b1;
               if_id_en_c    = 1'b1;
               id_ex_en_c    = 1'b1;
               ex_mem_en_c   = 1'b1;
               mem_wb_en_c   = 1'b1;
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
               wb_commit_c   = 1'b1;
            end else if (lu_hazard_c) begin
               // One bubble into EX; the load moves on and the hazard clears.
               id_ex_en_c    = 1'b1;
               ex_mem_en_c   = 1'b1;
               mem_wb_en_c   = 1'b1;
               id_ex_flush_c = 1'b1;
               wb_commit_c   = 1'b1;
            end else begin
               pc_en_c     = 1'b1;
               if_id_en_c  = 1'b1;
               id_ex_en_c  = 1'b1;
               ex_mem_en_c = 1'b1;
               mem_wb_en_c = 1'b1;
               wb_commit_c = 1'b1;
            end

            // Timeout only while frozen; a halt request waits for the freeze.
            if (freeze_c && (wait_cnt_q == WAIT_LAST)) begin
               state_d = ST_ERROR;
            end else if (!freeze_c && halt_req) begin
               state_d = ST_HALT;
            end

            if (!pc_en_c && (stall_cnt_q != CNT_MAX)) begin
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (if_id_flush_c && (flush_cnt_q != CNT_MAX)) begin
               flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
         end
         ST_HALT:  state_d = ST_HALT;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_ERROR;
      endcase
   end

   // While reset is held the pipe is frozen with NOPs forced into IF/ID, ID/EX.
   assign pc_en       = rst & pc_en_c;
   assign if_id_en    = rst & if_id_en_c;
   assign id_ex_en    = rst & id_ex_en_c;
   assign ex_mem_en   = rst & ex_mem_en_c;
   assign mem_wb_en   = rst & mem_wb_en_c;
   assign if_id_flush = ~rst | if_id_flush_c;
   assign id_ex_flush = ~rst | id_ex_flush_c;
   assign wb_commit   = rst & wb_commit_c;
   assign halted      = (state_q == ST_HALT);
   assign mem_error   = (state_q == ST_ERROR);
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_controller;

   localparam int unsigned MT = 4;
   localparam int unsigned CW = 4;
   localparam int          CMAX = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_is_load = 1'b0;
   logic          ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
   logic          halt_req = 1'b0;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic          if_id_flush, id_ex_flush, wb_commit, halted, mem_error;
   logic [CW-1:0] stall_count, flush_count;

   pipeline_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .wb_commit(wb_commit), .halted(halted), .mem_error(mem_error),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   // ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, wb_commit}
   typedef struct packed {
      logic [7:0]    ctl;
      logic          halted;
      logic          err;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
   } exp_t;

   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: 0 RUN, 1 HALT, 2 ERROR.
   int m_state = 0;
   int m_wait  = 0;
   int m_stall = 0;
   int m_flush = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      logic fr, lu;
      fr = mem_req & ~mem_ready;
      lu = ex_is_load && (ex_rd != 5'd0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      e.halted = 1'b0;
      e.err    = 1'b0;
      e.stall  = CW'(m_stall);
      e.flush  = CW'(m_flush);
      if (!rst) begin
         e.ctl   = 8'b0000_0110;
         e.stall = '0;
         e.flush = '0;
      end else if (m_state == 1) begin
         e.ctl    = 8'h00;
         e.halted = 1'b1;
      end else if (m_state == 2) begin
         e.ctl = 8'h00;
         e.err = 1'b1;
      end else if (fr)              e.ctl = 8'h00;
      else if (ex_branch_taken)     e.ctl = 8'hFF;
      else if (lu)                  e.ctl = 8'b0011_1011;
      else                          e.ctl = 8'b1111_1001;
      return e;
   endfunction

   // One cycle: called just after a falling edge with inputs already set.
   task automatic cycle(input string tag);
      exp_t e, p;
      logic fr;
      e = model_out();
      exp_q.push_back(e);
      #4;
      p = exp_q.pop_front();
      check({tag, ".ctl"}, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                               if_id_flush, id_ex_flush, wb_commit}), 32'(p.ctl));
      check({tag, ".halted"}, 32'(halted), 32'(p.halted));
      check({tag, ".mem_error"}, 32'(mem_error), 32'(p.err));
      check({tag, ".stall_count"}, 32'(stall_count), 32'(p.stall));
      check({tag, ".flush_count"}, 32'(flush_count), 32'(p.flush));
      @(posedge clk);
      fr = mem_req & ~mem_ready;
      if (!rst) begin
         m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      end else if (m_state == 0) begin
         if (!p.ctl[7] && m_stall != CMAX) m_stall++;
         if (p.ctl[2] && m_flush != CMAX) m_flush++;
         if (fr && m_wait == int'(MT) - 1) m_state = 2;
         else if (!fr && halt_req)         m_state = 1;
         m_wait = fr ? m_wait + 1 : 0;
      end else begin
         m_wait = 0;
      end
      @(negedge clk);
   endtask

   task automatic cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   task automatic idle();
      rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
      ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      cycles("reset", 2);
      rst = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      idle(); cycles("idle", 5);

      // Load-use through rs2, then x0 destination, rs1 path, unused source.
      ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      cycle("lu_rs2");
      idle(); ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
      cycle("lu_x0");
      idle(); ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      cycle("lu_rs1");
      idle(); ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
      cycle("lu_unused");

      // Branch beats load-use.
      idle(); ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      ex_branch_taken = 1'b1;
      cycle("br_lu");
      idle(); cycle("post_br");

      // Frozen branch: three held cycles then a single flush.
      do_reset();
      idle(); ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      cycles("frz_br", 3);
      mem_ready = 1'b1; cycle("frz_br_rel");
      idle(); cycle("frz_after");

      // Zero-wait memory advances normally.
      idle(); mem_req = 1'b1; mem_ready = 1'b1; cycles("zero_wait", 2);

      // Halt ignored while frozen, taken once the freeze clears; HALT is sticky.
      idle(); mem_req = 1'b1; halt_req = 1'b1; cycles("halt_frz", 2);
      mem_ready = 1'b1; cycle("halt_go");
      idle(); ex_branch_taken = 1'b1; cycles("halted", 3);
      idle(); ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      cycle("halted_lu");

      // Watchdog: broken wait restarts the count; then timeout beats halt_req.
      do_reset();
      idle(); mem_req = 1'b1; cycles("wd_pre", 3);
      mem_ready = 1'b1; cycle("wd_break");
      mem_ready = 1'b0; halt_req = 1'b1; cycles("wd_to", 6);
      idle(); ex_branch_taken = 1'b1; cycles("err_hold", 2);

      // Reset mid-error and mid-freeze leaves no residual wait count.
      do_reset();
      idle(); mem_req = 1'b1; cycles("rst_frz_a", 3);
      rst = 1'b0; cycle("rst_frz_rst");
      rst = 1'b1; cycles("rst_frz_b", 3);
      cycles("rst_frz_to", 2);

      // Counter saturation.
      do_reset();
      idle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
      cycles("sat_stall", 20);
      idle(); ex_branch_taken = 1'b1; cycles("sat_flush", 20);
      idle(); cycle("sat_end");

      if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
